// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP_INSTR / TRAP_HALT : special instruction words
//   state_t               : fetch state (RUN / HALT)
//   ifid_t                : IF/ID pipeline register payload
//   opcode()              : primary opcode field (bits 0..5, bit 0 = MSB)
package if_stage_pkg;

    localparam logic [0:31] NOP_INSTR = 32'h5400_0000;
    localparam logic [0:31] TRAP_HALT = 32'h4400_0300;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [0:31] instr;
        logic [0:31] pc4;
        logic        valid;
    } ifid_t;

    function automatic logic [0:5] opcode(input logic [0:31] w);
        return w[0:5];
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clock, reset : rising-edge clock, async active-low reset
//   load         : capture d (a real fetched instruction)
//   bubble       : insert NOP with valid cleared (wins over load)
//   d            : incoming instr/pc4/valid
//   q            : registered instr/pc4/valid
// With neither load nor bubble the register holds.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  load,
    input  logic  bubble,
    input  ifid_t d,
    output ifid_t q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q.instr <= NOP_INSTR;
            q.pc4   <= '0;
            q.valid <= 1'b0;
        end else if (bubble) begin
            // pc4 is left as-is: it is meaningless while valid is low
            q.instr <= NOP_INSTR;
            q.valid <= 1'b0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select, halt-trap detection
// and the IF/ID register feeding decode.
//   clock, reset   : rising-edge clock, async active-low reset
//   stall          : hold PC and IF/ID this cycle
//   branch         : taken redirect resolved in decode
//   branch_target  : redirect address (low 2 bits dropped)
//   imem_addr      : current PC to external IMEM
//   imem_data      : instruction at imem_addr (combinational)
//   instr_id/pc4_id/valid_id : IF/ID register outputs
//   halted         : trap has reached ID, fetch is frozen
// All 32-bit buses are [0:31], bit 0 is the MSB.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [0:31] RESET_PC     = 32'h0000_0000,
    parameter bit          HALT_ON_TRAP = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic [0:31] branch_target,
    output logic [0:31] imem_addr,
    input  logic [0:31] imem_data,
    output logic [0:31] instr_id,
    output logic [0:31] pc4_id,
    output logic        valid_id,
    output logic        halted
);

    state_t      state;
    logic [0:31] pc;
    logic [0:31] pc_plus4;
    logic        run;
    logic        trap_hit;
    logic        ifid_load;
    logic        ifid_bubble;
    ifid_t       ifid_d;
    ifid_t       ifid_q;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;   // wraps modulo 2^32
    assign run       = (state == RUN);
    assign trap_hit  = HALT_ON_TRAP && (imem_data == TRAP_HALT);

    // In HALT every edge writes a bubble: the first one replaces the trap,
    // later ones just rewrite the same NOP/0 value.
    assign ifid_bubble = run ? (!stall && branch) : 1'b1;
    assign ifid_load   = run && !stall && !branch;
    assign ifid_d      = '{instr: imem_data, pc4: pc_plus4, valid: 1'b1};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc     <= {RESET_PC[0:29], 2'b00};
            state  <= RUN;
            halted <= 1'b0;
        end else if (run && !stall) begin
            if (branch) begin
                pc <= {branch_target[0:29], 2'b00};
            end else if (trap_hit) begin
                // pc holds on the trap so imem_addr keeps pointing at it
                state  <= HALT;
                halted <= 1'b1;
            end else begin
                pc <= pc_plus4;
            end
        end
    end

    if_id_reg u_if_id (
        .clock  (clock),
        .reset  (reset),
        .load   (ifid_load),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign instr_id = ifid_q.instr;
    assign pc4_id   = ifid_q.pc4;
    assign valid_id = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] NOP  = 32'h5400_0000;
    localparam logic [31:0] TRAP = 32'h4400_0300;
    localparam logic [31:0] DEF  = 32'h2001_0001;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr_id;
    logic [31:0] pc4_id;
    logic        valid_id;
    logic        halted;

    // bench-owned IMEM: one optional trap override
    logic        trap_en = 1'b0;
    logic [31:0] trap_addr = '0;

    int checks = 0;
    int failures = 0;

    // reference state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halted;

    always #5 clock = ~clock;

    assign imem_data = (trap_en && imem_addr == trap_addr) ? TRAP : DEF;

    if_stage dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .branch       (branch),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .instr_id     (instr_id),
        .pc4_id       (pc4_id),
        .valid_id     (valid_id),
        .halted       (halted)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (trap_en && a == trap_addr) ? TRAP : DEF;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
    endtask

    // One rising edge of the fetch stage, expressed directly from the rules.
    task automatic model_edge(input logic s, input logic b, input logic [31:0] t);
        logic [31:0] w;
        if (m_halted) begin
            m_instr = NOP; m_valid = 1'b0;
        end else if (s) begin
            // everything holds
        end else if (b) begin
            m_pc = t & 32'hFFFF_FFFC; m_instr = NOP; m_valid = 1'b0;
        end else begin
            w = mem(m_pc);
            m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            if (w == TRAP) m_halted = 1'b1;
            else m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"}, imem_addr, m_pc);
        chk({tag, ".instr"}, instr_id, m_instr);
        chk({tag, ".valid"}, {31'd0, valid_id}, {31'd0, m_valid});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
        if (m_valid) chk({tag, ".pc4"}, pc4_id, m_pc4);
    endtask

    task automatic step(input string tag, input logic s, input logic b, input logic [31:0] t);
        @(negedge clock);
        stall = s; branch = b; branch_target = t;
        model_edge(s, b, t);
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    // Async reset asserted between edges; released just after the following edge.
    task automatic do_reset(input string tag);
        @(posedge clock);
        #2;
        reset = 1'b0;
        stall = 1'b0; branch = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, ".pc4"}, pc4_id, 32'h0);
        @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        int halt_cnt;
        model_reset();
        do_reset("reset");

        // 1: sequential fetch
        chk("seq0.addr", imem_addr, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step("seq", 0, 0, 0);
            chk("seq.addr_abs", imem_addr, 32'(i * 4));
            chk("seq.pc4_abs", pc4_id, 32'(i * 4));
        end

        // 2: stall holds PC and IF/ID
        step("stall1", 1, 0, 0);
        step("stall2", 1, 0, 0);
        chk("stall.addr_abs", imem_addr, 32'd16);
        chk("stall.pc4_abs", pc4_id, 32'd16);
        step("unstall", 0, 0, 0);
        chk("unstall.addr_abs", imem_addr, 32'd20);

        // 3: branch with misaligned target
        step("branch", 0, 1, 32'h0000_0103);
        chk("branch.addr_abs", imem_addr, 32'h100);
        chk("branch.instr_abs", instr_id, NOP);
        step("after_branch", 0, 0, 0);
        chk("after_branch.pc4_abs", pc4_id, 32'h104);

        // 4: stall wins over branch
        step("stall_branch", 1, 1, 32'h0000_0200);
        chk("stall_branch.addr_abs", imem_addr, 32'h104);
        step("branch_late", 0, 1, 32'h0000_0200);
        chk("branch_late.addr_abs", imem_addr, 32'h200);

        // 5a: trap at 24 halts; later stall/branch ignored
        trap_en = 1'b1; trap_addr = 32'd24;
        do_reset("reset_trap");
        for (int i = 0; i < 7; i++) step("to_trap", 0, 0, 0);
        chk("trap.instr_abs", instr_id, TRAP);
        chk("trap.halted_abs", {31'd0, halted}, 32'd1);
        step("halt1", 0, 1, 32'h0000_0400);
        step("halt2", 1, 0, 0);
        step("halt3", 0, 0, 0);
        chk("halt.addr_abs", imem_addr, 32'd24);
        chk("halt.valid_abs", {31'd0, valid_id}, 32'd0);

        // 5b: squashed trap does not halt
        do_reset("reset_squash");
        for (int i = 0; i < 6; i++) step("to_squash", 0, 0, 0);
        step("squash", 0, 1, 32'h0000_0040);
        chk("squash.halted_abs", {31'd0, halted}, 32'd0);
        step("post_squash", 0, 0, 0);

        // 6: PC wrap and async reset mid-run
        trap_en = 1'b0;
        step("to_top", 0, 1, 32'hFFFF_FFFF);
        chk("top.addr_abs", imem_addr, 32'hFFFF_FFFC);
        step("wrap", 0, 0, 0);
        chk("wrap.addr_abs", imem_addr, 32'h0);
        chk("wrap.pc4_abs", pc4_id, 32'h0);
        step("pre_reset", 0, 0, 0);
        do_reset("reset_mid");

        // random phase against the reference model
        trap_en = 1'b1; trap_addr = 32'h0000_0040;
        halt_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            logic s, b;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 6) == 0);
            t = $urandom_range(0, 32'h7F);
            if ($urandom_range(0, 9) == 0) t = $urandom();
            if ($urandom_range(0, 60) == 0 || halt_cnt > 4) begin
                do_reset("rnd_reset");
                halt_cnt = 0;
            end else begin
                step("rnd", s, b, t);
                if (m_halted) halt_cnt++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
